// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, ALU op codes, op2 source selects,
// and the mul/div sequencer state encoding. Imported by the controller and
// by the execute stage so both sides agree on the encodings.
package cpu_pkg;

  localparam int CPU_XLEN = 32;

  localparam logic [7:0] OP_ADD  = 8'd0;
  localparam logic [7:0] OP_ADDI = 8'd1;
  localparam logic [7:0] OP_SUB  = 8'd2;
  localparam logic [7:0] OP_MUL  = 8'd3;
  localparam logic [7:0] OP_DIV  = 8'd4;
  localparam logic [7:0] OP_SLL  = 8'd5;
  localparam logic [7:0] OP_SRL  = 8'd6;
  localparam logic [7:0] OP_AND  = 8'd7;
  localparam logic [7:0] OP_OR   = 8'd8;
  localparam logic [7:0] OP_NOT  = 8'd9;
  localparam logic [7:0] OP_XOR  = 8'd10;
  localparam logic [7:0] OP_LUI  = 8'd11;

  localparam logic [1:0] OP2_RS2  = 2'b00;
  localparam logic [1:0] OP2_UIMM = 2'b01;
  localparam logic [1:0] OP2_IIMM = 2'b10;
  localparam logic [1:0] OP2_ZERO = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE    = 2'd0,
    MD_MUL_RUN = 2'd1,
    MD_DIV_RUN = 2'd2,
    MD_FIN     = 2'd3
  } md_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Controller <-> execute stage bundle.
//   master (controller): drives alu_en, alu_op, op2_dir, instr, rs1/rs2 data;
//                        observes result, busy, done.
//   slave  (alu_exec):   the reverse.
interface alu_exec_if #(parameter int XLEN = 32);
  logic            alu_en;
  logic [7:0]      alu_op;
  logic [1:0]      op2_dir;
  logic [31:0]     instr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] result;
  logic            busy;
  logic            done;

  modport master (
    output alu_en, alu_op, op2_dir, instr, rs1_data, rs2_data,
    input  result, busy, done
  );

  modport slave (
    input  alu_en, alu_op, op2_dir, instr, rs1_data, rs2_data,
    output result, busy, done
  );
endinterface

// File: rtl/alu_execmuldiv_note.sv
// Iterative multiply / signed divide sequencer.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start, is_div  launch request (honoured only when idle) and op select
//   a, b           operands, captured on start
//   busy           high in MUL_RUN, DIV_RUN and FIN
//   done           high during FIN: res is final and gets written on this edge
//   res            low product word, or sign-corrected quotient
module alu_muldiv import cpu_pkg::*; #(
  parameter int XLEN = CPU_XLEN,
  parameter int ITER = CPU_XLEN   // must equal XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_div,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(ITER);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // mc: multiplicand / divisor; mp: multiplier / dividend->quotient;
  // acc: product accumulator / partial remainder
  logic [XLEN-1:0] mc_q, mc_d, mp_q, mp_d, acc_q, acc_d;
  logic            div_q, div_d, neg_q, neg_d;
  logic [XLEN:0]   rem_sh, rem_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    acc_d    = acc_q;
    div_d    = div_q;
    neg_d    = neg_q;
    // restoring step: shift next dividend bit into remainder, trial subtract;
    // the remainder stays below the divisor so bit XLEN of the diff is the borrow
    rem_sh   = {acc_q, mp_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, mc_q};
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          cnt_d = CW'(ITER - 1);
          acc_d = '0;
          div_d = is_div;
          if (is_div) begin
            mc_d    = b[XLEN-1] ? -b : b;
            mp_d    = a[XLEN-1] ? -a : a;
            neg_d   = a[XLEN-1] ^ b[XLEN-1];
            state_d = MD_DIV_RUN;
          end else begin
            mc_d    = a;
            mp_d    = b;
            neg_d   = 1'b0;
            state_d = MD_MUL_RUN;
          end
        end
      end
      MD_MUL_RUN: begin
        if (mp_q[0]) acc_d = acc_q + mc_q;
        mc_d  = mc_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = MD_FIN;
      end
      MD_DIV_RUN: begin
        if (!rem_diff[XLEN]) begin
          acc_d = rem_diff[XLEN-1:0];
          mp_d  = {mp_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[XLEN-1:0];
          mp_d  = {mp_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = MD_FIN;
      end
      MD_FIN:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy = (state_q != MD_IDLE);
  assign done = (state_q == MD_FIN);
  assign res  = div_q ? (neg_q ? -mp_q : mp_q) : acc_q;

endmodule

// File: rtl/alu_exec.sv
// Execute stage: op2 source mux, single-cycle ALU, divide special cases and
// the write-back result register. MUL and non-trivial DIV are handed to
// alu_muldiv; the controller waits on busy/done.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         alu_exec_if.slave: alu_en/alu_op/op2_dir/instr/rs1/rs2 in,
//               result/busy/done out
module alu_exec import cpu_pkg::*; #(
  parameter int XLEN = CPU_XLEN,  // only 32 supported (immediate layout)
  parameter int ITER = CPU_XLEN
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] op1, op2, sc_res, md_res, result_q;
  logic            done_q, md_busy, md_done;
  logic            accept, is_mul, is_div, div_zero, div_ovf, md_start;
  logic            unused_instr;

  assign unused_instr = ^bus.instr[11:0];

  assign op1 = bus.rs1_data;

  always_comb begin
    case (bus.op2_dir)
      OP2_RS2:  op2 = bus.rs2_data;
      OP2_UIMM: op2 = {bus.instr[31:12], 12'b0};
      OP2_IIMM: op2 = {{20{bus.instr[31]}}, bus.instr[31:20]};
      default:  op2 = '0;
    endcase
  end

  assign is_mul   = (bus.alu_op == OP_MUL);
  assign is_div   = (bus.alu_op == OP_DIV);
  assign div_zero = (op2 == '0);
  // INT_MIN / -1 overflows the quotient; answer is INT_MIN itself
  assign div_ovf  = (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

  always_comb begin
    case (bus.alu_op)
      OP_ADD, OP_ADDI: sc_res = op1 + op2;
      OP_SUB:          sc_res = op1 - op2;
      OP_SLL:          sc_res = op1 << op2[SHW-1:0];
      OP_SRL:          sc_res = op1 >> op2[SHW-1:0];
      OP_AND:          sc_res = op1 & op2;
      OP_OR:           sc_res = op1 | op2;
      OP_NOT:          sc_res = ~op1;
      OP_XOR:          sc_res = op1 ^ op2;
      OP_LUI:          sc_res = op2;
      OP_DIV:          sc_res = div_zero ? '1 : op1;  // only reached for special cases
      default:         sc_res = '0;
    endcase
  end

  // FIN counts as busy, so a request there is dropped rather than queued
  assign accept   = bus.alu_en && !md_busy;
  assign md_start = accept && (is_mul || (is_div && !div_zero && !div_ovf));

  alu_muldiv #(.XLEN(XLEN), .ITER(ITER)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (is_div),
    .a      (op1),
    .b      (op2),
    .busy   (md_busy),
    .done   (md_done),
    .res    (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept && !md_start) begin
        result_q <= sc_res;
        done_q   <= 1'b1;
      end else if (md_done) begin
        result_q <= md_res;
        done_q   <= 1'b1;
      end
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = md_busy;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  alu_exec_if #(.XLEN(32)) bus ();

  alu_exec #(.XLEN(32), .ITER(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [1:0] dir,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] ins);
    bus.alu_op   = op;
    bus.op2_dir  = dir;
    bus.rs1_data = rs1;
    bus.rs2_data = rs2;
    bus.instr    = ins;
  endtask

  // called at a negedge; single-cycle op completes in the next cycle
  task automatic run_single(input string tag, input logic [7:0] op, input logic [1:0] dir,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [31:0] ins, input logic [31:0] exp);
    drive(op, dir, rs1, rs2, ins);
    bus.alu_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.alu_en   = 1'b0;
    bus.rs1_data = ~rs1;
    bus.rs2_data = ~rs2;
    bus.instr    = ~ins;
    check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_res"}, bus.result, exp);
    @(negedge clk);
    check({tag, "_hold"}, bus.result, exp);
    check({tag, "_done_clr"}, {31'b0, bus.done}, 32'd0);
  endtask

  // iterative op; returns at the negedge of the done cycle
  task automatic run_long(input string tag, input logic [7:0] op,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] exp, input bit pulse, input logic [31:0] held);
    int n;
    int nbusy;
    bit got;
    n = 0; nbusy = 0; got = 1'b0;
    drive(op, OP2_RS2, rs1, rs2, 32'h0);
    bus.alu_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.alu_en   = 1'b0;
    bus.rs1_data = ~rs1;
    bus.rs2_data = ~rs2;
    while (n < 60 && !got) begin
      if (bus.done) got = 1'b1;
      else begin
        if (bus.busy) nbusy++;
        if (pulse && n == 10) begin
          drive(OP_ADD, OP2_RS2, 32'd1, 32'd1, 32'h0);
          bus.alu_en = 1'b1;
        end
        if (pulse && n == 11) bus.alu_en = 1'b0;
        if (pulse && n == 12) check({tag, "_ign_done"}, {31'b0, bus.done}, 32'd0);
        if (pulse && n == 20) check({tag, "_held"}, bus.result, held);
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_lat"}, n, 32'd33);
    check({tag, "_busy_cnt"}, nbusy, 32'd33);
    check({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_res"}, bus.result, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.alu_en = 1'b0;
    drive(8'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("rst_res", bus.result, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_single("add",  OP_ADD,  OP2_RS2,  32'd5,  32'd7, 32'h0, 32'd12);
    run_single("addi", OP_ADDI, OP2_IIMM, 32'd10, 32'd0, 32'hFFD00000, 32'd7);
    run_single("sub",  OP_SUB,  OP2_RS2,  32'd10, 32'd3, 32'h0, 32'd7);
    run_single("sll",  OP_SLL,  OP2_RS2,  32'd1,  32'd35, 32'h0, 32'd8);
    run_single("srl",  OP_SRL,  OP2_RS2,  32'h80000000, 32'd4, 32'h0, 32'h08000000);
    run_single("and",  OP_AND,  OP2_RS2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000);
    run_single("or",   OP_OR,   OP2_RS2,  32'hF0F0F0F0, 32'h0F0F0000, 32'h0, 32'hFFFFF0F0);
    run_single("xor",  OP_XOR,  OP2_RS2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0FF00FF0);
    run_single("not",  OP_NOT,  OP2_RS2,  32'h0000FFFF, 32'h12345678, 32'h0, 32'hFFFF0000);
    run_single("zero_op2", OP_ADD, OP2_ZERO, 32'h55, 32'h1000, 32'h0, 32'h55);
    run_single("undef12", 8'd12, OP2_RS2, 32'd9, 32'd9, 32'h0, 32'h0);
    run_single("lui",  OP_LUI,  OP2_UIMM, 32'd99, 32'd0, 32'h12345000, 32'h12345000);

    // alu_en held high: one op per edge
    drive(OP_ADD, OP2_RS2, 32'd1, 32'd2, 32'h0);
    bus.alu_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_res0", bus.result, 32'd3);
    bus.rs1_data = 32'd10;
    @(posedge clk);
    @(negedge clk);
    bus.alu_en = 1'b0;
    check("b2b_res1", bus.result, 32'd12);
    check("b2b_done1", {31'b0, bus.done}, 32'd1);
    @(negedge clk);
    run_single("lui2", OP_LUI, OP2_UIMM, 32'd0, 32'd0, 32'h12345000, 32'h12345000);

    run_long("mul",   OP_MUL, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, 1'b1, 32'h12345000);
    run_long("mul76", OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 32'h0);
    run_long("div_n7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 32'h0);
    run_long("div_7_n2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 32'h0);
    run_long("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 32'h0);
    // start issued in the done cycle
    run_single("div0", OP_DIV, OP2_RS2, 32'd5, 32'd0, 32'h0, 32'hFFFFFFFF);
    run_single("divovf", OP_DIV, OP2_RS2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // reset in the middle of a MUL
    drive(OP_MUL, OP2_RS2, 32'd5, 32'd6, 32'h0);
    bus.alu_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.alu_en = 1'b0;
    repeat (9) @(negedge clk);
    check("mrst_busy_pre", {31'b0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", {31'b0, bus.busy}, 32'd0);
    check("mrst_done", {31'b0, bus.done}, 32'd0);
    check("mrst_res", bus.result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mrst_res_after", bus.result, 32'h0);
    check("mrst_busy_after", {31'b0, bus.busy}, 32'd0);
    run_single("sub35", OP_SUB, OP2_RS2, 32'd3, 32'd5, 32'h0, 32'hFFFFFFFE);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
